// File: rtl/axi_rd_arbiter_pkg.sv
// rtl/axi_rd_arbiter_pkg.sv - shared constants for the AXI read-channel arbiter
//
// Purpose: AXI ID / burst encodings, AR FSM state encodings and grant-owner
//          encodings shared by the arbiter top and its sub-modules.
// Ports:   none (package).

package axi_rd_arbiter_pkg;

   // Fixed ARID per requester; returning beats are steered by RID bit 0.
   localparam logic [3:0] AXI_ID_INST    = 4'd0;
   localparam logic [3:0] AXI_ID_DATA    = 4'd1;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   // AR channel FSM.
   localparam logic [0:0] AR_IDLE        = 1'b0;
   localparam logic [0:0] AR_SEND        = 1'b1;

   // Grant owner, also the low bit of the issued ARID.
   localparam logic       GRANT_INST     = 1'b0;
   localparam logic       GRANT_DATA     = 1'b1;

endpackage

// File: rtl/axi_rd_arbiter_rd_outst_cnt.sv
// rtl/axi_rd_arbiter_rd_outst_cnt.sv - per-ID outstanding read counter with full flag
//
// Purpose: counts reads issued but not yet returned for one AXI ID and flags
//          when the in-flight limit is reached.
// Ports:
//   clk     in   clock
//   reset   in   asynchronous active-high reset, clears the count
//   i_inc   in   a read for this ID was granted this cycle
//   i_dec   in   a read beat for this ID returned this cycle
//   o_full  out  count has reached MAX_OUTST, no further grants allowed

module rd_outst_cnt #(
   parameter int MAX_OUTST = 2,
   parameter int CNT_W     = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_inc,
   input  logic i_dec,
   output logic o_full
);

   localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_OUTST);
   localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else begin
         case ({i_inc, i_dec})
            2'b10: r_cnt <= r_cnt + LP_ONE;
            // A return with nothing outstanding is a system error; hold at
            // zero rather than wrap so the requester is not locked out.
            2'b01: if (r_cnt != '0) r_cnt <= r_cnt - LP_ONE;
            // Grant and return together cancel out.
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign o_full = (r_cnt >= LP_MAX);

   a_no_underflow: assert property (@(posedge clk) disable iff (reset)
      i_dec |-> (r_cnt != '0));

endmodule

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - round-robin arbiter sharing one AXI AR/R channel between inst and data ports
//
// Purpose: accepts SRAM-like read requests from the instruction-fetch port
//          (ARID 0) and the data port (ARID 1), issues them one at a time on
//          the AXI AR channel, and steers R beats back by RID. Per-ID
//          outstanding counters bound the number of reads in flight.
// Ports:
//   clk, reset                         clock, async active-high reset
//   inst_req/size/addr                 inst read request (held until addr_ok)
//   inst_addr_ok, inst_data_ok/rdata   inst accept pulse, read data return
//   data_req/size/addr                 data read request (held until addr_ok)
//   data_addr_ok, data_data_ok/rdata   data accept pulse, read data return
//   arid/araddr/arlen/arsize/arburst   AXI AR payload (single-beat INCR)
//   arvalid/arready                    AXI AR handshake
//   rid/rdata/rvalid/rready            AXI R channel (rready tied high)

import axi_rd_arbiter_pkg::*;

module axi_rd_arbiter #(
   parameter int MAX_OUTST = 2,
   parameter int CNT_W     = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_req,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic        rvalid,
   output logic        rready
);

   logic [0:0]  r_state;
   logic [31:0] r_araddr;
   logic [1:0]  r_arsize;
   logic        r_arid;
   logic        r_last_grant;

   logic        w_idle;
   logic        w_inst_full;
   logic        w_data_full;
   logic        w_inst_elig;
   logic        w_data_elig;
   logic        w_grant_inst;
   logic        w_grant_data;
   logic        w_inst_ret;
   logic        w_data_ret;

   assign w_idle      = (r_state == AR_IDLE);
   assign w_inst_elig = inst_req & ~w_inst_full;
   assign w_data_elig = data_req & ~w_data_full;

   // On a tie the requester that did not win last time is granted; last_grant
   // resets to inst so data wins the first tie.
   assign w_grant_data = w_idle & w_data_elig &
                         (~w_inst_elig | (r_last_grant == GRANT_INST));
   assign w_grant_inst = w_idle & w_inst_elig &
                         (~w_data_elig | (r_last_grant == GRANT_DATA));

   assign inst_addr_ok = w_grant_inst;
   assign data_addr_ok = w_grant_data;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= AR_IDLE;
         r_araddr     <= '0;
         r_arsize     <= '0;
         r_arid       <= GRANT_INST;
         r_last_grant <= GRANT_INST;
      end else if (r_state == AR_IDLE) begin
         if (w_grant_data) begin
            r_araddr     <= data_addr;
            r_arsize     <= data_size;
            r_arid       <= GRANT_DATA;
            r_last_grant <= GRANT_DATA;
            r_state      <= AR_SEND;
         end else if (w_grant_inst) begin
            r_araddr     <= inst_addr;
            r_arsize     <= inst_size;
            r_arid       <= GRANT_INST;
            r_last_grant <= GRANT_INST;
            r_state      <= AR_SEND;
         end
      end else begin
         // Payload registers hold until the handshake; returning through
         // IDLE gives a minimum AR spacing of two cycles.
         if (arready) r_state <= AR_IDLE;
      end
   end

   assign arvalid = (r_state == AR_SEND);
   assign araddr  = r_araddr;
   assign arsize  = {1'b0, r_arsize};
   assign arid    = (r_arid == GRANT_DATA) ? AXI_ID_DATA : AXI_ID_INST;
   assign arlen   = 8'd0;
   assign arburst = AXI_BURST_INCR;

   // R path: always ready, steer by RID bit 0.
   assign rready       = 1'b1;
   assign w_inst_ret   = rvalid & (rid[0] == AXI_ID_INST[0]);
   assign w_data_ret   = rvalid & (rid[0] == AXI_ID_DATA[0]);
   assign inst_data_ok = w_inst_ret;
   assign data_data_ok = w_data_ret;
   assign inst_rdata   = rdata;
   assign data_rdata   = rdata;

   rd_outst_cnt #(
      .MAX_OUTST (MAX_OUTST),
      .CNT_W     (CNT_W)
   ) u_inst_cnt (
      .clk    (clk),
      .reset  (reset),
      .i_inc  (w_grant_inst),
      .i_dec  (w_inst_ret),
      .o_full (w_inst_full)
   );

   rd_outst_cnt #(
      .MAX_OUTST (MAX_OUTST),
      .CNT_W     (CNT_W)
   ) u_data_cnt (
      .clk    (clk),
      .reset  (reset),
      .i_inc  (w_grant_data),
      .i_dec  (w_data_ret),
      .o_full (w_data_full)
   );

   // Only IDs 0 and 1 are ever issued, so upper RID bits must be zero.
   a_rid_range: assert property (@(posedge clk) disable iff (reset)
      rvalid |-> (rid[3:1] == 3'b000));

   a_one_addr_ok: assert property (@(posedge clk) disable iff (reset)
      !(inst_addr_ok && data_addr_ok));

endmodule
